// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
package cdb_pkg;

  localparam int TAG_W_DEF  = 3;
  localparam int DATA_W_DEF = 32;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  localparam logic [TAG_W_DEF-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Small per-source result FIFO: head/tail pointers wrapping modulo DEPTH, a
// registered count, and a synchronous clear used for mispredict flush.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = $bits(cdb_entry_t)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     storage [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = storage[head_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= next_ptr(tail_ptr);
      if (do_pop)  head_ptr <= next_ptr(head_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && do_push) storage[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: two source FIFOs (ALU, memory), one registered broadcast per cycle.
// Define CDB_RR_EN for round-robin arbitration; default is fixed memory-over-ALU.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic [DATA_W-1:0] mem_data,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_src
);

  // Handshake: a source transfers on a rising edge where valid && ready; ready
  // depends only on rst_n, flush and the registered FIFO count, never on valid.

  localparam int ENTRY_W = TAG_W + DATA_W;
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [TAG_W-1:0] NO_TAG    = TAG_W'(TAG_NONE);

  logic               alu_push, mem_push;
  logic               alu_pop, mem_pop;
  logic               alu_full, mem_full;
  logic               alu_empty, mem_empty;
  logic [CNT_W-1:0]   alu_count, mem_count;
  logic [ENTRY_W-1:0] alu_head, mem_head, win_head;

  assign alu_ready = rst_n && !flush && (alu_count < CNT_DEPTH);
  assign mem_ready = rst_n && !flush && (mem_count < CNT_DEPTH);

  // Tag-0 results are consumed by the handshake but never stored.
  assign alu_push = alu_valid && alu_ready && !alu_full && (alu_tag != NO_TAG);
  assign mem_push = mem_valid && mem_ready && !mem_full && (mem_tag != NO_TAG);

  cdb_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (alu_push),
    .push_data ({alu_tag, alu_data}),
    .pop       (alu_pop),
    .head      (alu_head),
    .count     (alu_count),
    .full      (alu_full),
    .empty     (alu_empty)
  );

  cdb_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_mem_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (mem_push),
    .push_data ({mem_tag, mem_data}),
    .pop       (mem_pop),
    .head      (mem_head),
    .count     (mem_count),
    .full      (mem_full),
    .empty     (mem_empty)
  );

`ifdef CDB_RR_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      last_grant <= SRC_MEM;
    end else if (alu_pop) begin
      last_grant <= SRC_ALU;
    end else if (mem_pop) begin
      last_grant <= SRC_MEM;
    end
  end

  always_comb begin
    alu_pop = 1'b0;
    mem_pop = 1'b0;
    if (!alu_empty && !mem_empty) begin
      alu_pop = (last_grant == SRC_MEM);
      mem_pop = (last_grant == SRC_ALU);
    end else begin
      alu_pop = !alu_empty;
      mem_pop = !mem_empty;
    end
  end
`else
  always_comb begin
    alu_pop = 1'b0;
    mem_pop = 1'b0;
    mem_pop = !mem_empty;
    alu_pop = !alu_empty && mem_empty;
  end
`endif

  assign win_head = mem_pop ? mem_head : alu_head;

  // On idle cycles data and source hold; only valid and tag return to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= SRC_ALU;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
    end else if (alu_pop || mem_pop) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= win_head[ENTRY_W-1 -: TAG_W];
      cdb_data  <= win_head[DATA_W-1:0];
      cdb_src   <= mem_pop ? SRC_MEM : SRC_ALU;
    end else begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
    end
  end

endmodule
